// File: rtl/vga_anim_sequencer.sv
// Frame-synchronous animation controller: frame/step tick generation, button debounce,
// and a grow/hold/shrink/hold FSM whose outputs change only during vertical blanking.
module vga_anim_sequencer #(
  parameter int FRAME_LINE      = 480,
  parameter int FRAMES_PER_STEP = 4,
  parameter int SIZE_MAX        = 31,
  parameter int SIZE_W          = 5,
  parameter int HOLD_STEPS      = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              button,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  output logic              frame_tick,
  output logic              step_tick,
  output logic [SIZE_W-1:0] size,
  output logic [2:0]        color_idx,
  output logic [2:0]        state,
  output logic              paused
);

  localparam int DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SIZE_W-1:0] SIZE_TOP = SIZE_W'(SIZE_MAX);

  typedef enum logic [2:0] {
    GROW       = 3'd0,
    HOLD_BIG   = 3'd1,
    SHRINK     = 3'd2,
    HOLD_SMALL = 3'd3,
    PAUSE      = 3'd4
  } state_t;

  logic [DIV_W-1:0]  div_cnt;
  logic              div_wrap, step_now;
  logic              sync1, sync2, deb_level, deb_done, press;
  logic [DEB_W-1:0]  deb_cnt;
  state_t            state_q, state_n, resume_q, resume_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [SIZE_W-1:0] size_n;
  logic [2:0]        color_n;

  assign div_wrap = (div_cnt == DIV_W'(FRAMES_PER_STEP - 1));
  assign step_now = frame_tick && div_wrap;

  // NOTE: every register is written with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame_tick <= 1'b0;
      step_tick  <= 1'b0;
      div_cnt    <= '0;
    end else begin
      frame_tick <= (h_count == 10'd0) && (v_count == 10'(FRAME_LINE));
      step_tick  <= step_now;
      if (frame_tick) div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted level,
  // so any bounce back restarts the stability window.
  assign deb_done = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign press    = sync2 && !deb_level && deb_done;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= GROW;
      resume_q  <= GROW;
      hold_q    <= '0;
      size      <= '0;
      color_idx <= '0;
      paused    <= 1'b0;
    end else begin
      state_q   <= state_n;
      resume_q  <= resume_n;
      hold_q    <= hold_n;
      size      <= size_n;
      color_idx <= color_n;
      paused    <= (state_n == PAUSE);
    end
  end

  assign state = state_q;

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    state_n  = state_q;
    resume_n = resume_q;
    hold_n   = hold_q;
    size_n   = size;
    color_n  = color_idx;
    if (press) begin
      // Press wins over a coincident step; the step is dropped for the animation.
      if (state_q == PAUSE) begin
        state_n = resume_q;
      end else begin
        state_n  = PAUSE;
        resume_n = state_q;
      end
    end else if (step_now && state_q != PAUSE) begin
      color_n = color_idx + 3'd1;
      unique case (state_q)
        GROW: begin
          if (size < SIZE_TOP) size_n = size + 1'b1;
          if (size_n == SIZE_TOP) begin
            state_n = HOLD_BIG;
            hold_n  = '0;
          end
        end
        HOLD_BIG: begin
          if (hold_q == HOLD_W'(HOLD_STEPS - 1)) begin
            state_n = SHRINK;
            hold_n  = '0;
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
        SHRINK: begin
          if (size != '0) size_n = size - 1'b1;
          if (size_n == '0) begin
            state_n = HOLD_SMALL;
            hold_n  = '0;
          end
        end
        HOLD_SMALL: begin
          if (hold_q == HOLD_W'(HOLD_STEPS - 1)) begin
            state_n = GROW;
            hold_n  = '0;
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
